// File: rtl/count_pkg.sv
// Shared types and helpers for the count16 sequence checker.
// Holds the FSM state encoding and the modular successor function.
package count_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    UNSYNC,
    SYNCING,
    LOCKED
  } state_e;

  function automatic logic [31:0] next_val(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return (v + 32'd1) & m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Monitor for a free-running up-counter: locks onto the sequence,
// flags skips/repeats and reports legal wrap-arounds.
module count_seq_checker
  import count_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_clr,
  input  logic             stat_clr,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt
);

  localparam int RUN_W = 4;

  state_e           state, state_n;
  logic [WIDTH-1:0] exp_v, exp_n;
  logic [RUN_W-1:0] run, run_n;
  logic             locked_n;
  logic             err_n;
  logic             wrap_n;
  logic [WIDTH-1:0] succ;
  logic             match;

  assign succ  = WIDTH'(next_val(32'(cnt_in), WIDTH));
  assign match = (cnt_in == exp_v) ||
                 (cnt_clr && (cnt_in == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= UNSYNC;
      exp_v  <= '0;
      run    <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_n;
      exp_v  <= exp_n;
      run    <= run_n;
      locked <= locked_n;
      err    <= err_n;
      wrap   <= wrap_n;
    end
  end

  always_comb begin
    state_n  = state;
    exp_n    = exp_v;
    run_n    = run;
    locked_n = locked;
    err_n    = 1'b0;
    wrap_n   = 1'b0;
    if (en) begin
      exp_n = succ;
      unique case (state)
        UNSYNC: begin
          run_n   = RUN_W'(1);
          state_n = SYNCING;
        end
        SYNCING: begin
          if (match) begin
            run_n = run + RUN_W'(1);
            if (run_n == RUN_W'(LOCK_CNT)) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else begin
            run_n = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            // expected 0 means the previous sample was the max value
            wrap_n = (cnt_in == '0) && (exp_v == '0);
          end else begin
            err_n    = 1'b1;
            locked_n = 1'b0;
            run_n    = RUN_W'(1);
            state_n  = SYNCING;
          end
        end
        default: begin
          state_n  = UNSYNC;
          locked_n = 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (err_n),
    .clr   (stat_clr),
    .q     (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (wrap_n),
    .clr   (stat_clr),
    .q     (wrap_cnt)
  );

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomized and directed bench for count_seq_checker.
// A sample-history reference model predicts every output.
module tb_count_seq_checker;

  localparam int LOCK = 3;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] cnt_in;
  logic       cnt_clr;
  logic       stat_clr;
  logic       locked;
  logic       err;
  logic       wrap;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state: last accepted sample and streak length
  bit m_has;
  int m_prev;
  int m_run;
  bit m_locked;
  bit m_err;
  bit m_wrap;
  int m_errc;
  int m_wrapc;

  count_seq_checker #(
    .WIDTH    (4),
    .LOCK_CNT (LOCK),
    .CNT_W    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cnt_in   (cnt_in),
    .cnt_clr  (cnt_clr),
    .stat_clr (stat_clr),
    .locked   (locked),
    .err      (err),
    .wrap     (wrap),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  task automatic model_reset();
    m_has = 0; m_prev = 0; m_run = 0; m_locked = 0;
    m_err = 0; m_wrap = 0; m_errc = 0; m_wrapc = 0;
  endtask

  task automatic model(input bit e, input int c, input bit cc, input bit sc);
    bit ok;
    m_err  = 0;
    m_wrap = 0;
    if (e) begin
      ok = m_has && ((c == (m_prev + 1) % 16) || (cc && c == 0));
      if (m_locked) begin
        if (ok) m_wrap = (m_prev == 15) && (c == 0);
        else begin
          m_err = 1; m_locked = 0; m_run = 1;
        end
      end else if (ok) begin
        m_run++;
        if (m_run >= LOCK) m_locked = 1;
      end else begin
        m_run = 1;
      end
      m_prev = c;
      m_has  = 1;
    end
    if (sc) begin
      m_errc = 0; m_wrapc = 0;
    end else begin
      if (m_err && m_errc < 255) m_errc++;
      if (m_wrap && m_wrapc < 255) m_wrapc++;
    end
  endtask

  task automatic compare_all();
    check("locked", int'(locked), int'(m_locked));
    check("err", int'(err), int'(m_err));
    check("wrap", int'(wrap), int'(m_wrap));
    check("err_cnt", int'(err_cnt), m_errc);
    check("wrap_cnt", int'(wrap_cnt), m_wrapc);
  endtask

  task automatic step(input bit e, input int c, input bit cc, input bit sc);
    @(negedge clk);
    en = e; cnt_in = 4'(c); cnt_clr = cc; stat_clr = sc;
    @(posedge clk);
    model(e, c, cc, sc);
    #1;
    compare_all();
  endtask

  task automatic s(input int c);
    step(1'b1, c % 16, 1'b0, 1'b0);
  endtask

  task automatic lock_at(input int b);
    s(b); s(b + 1); s(b + 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0; en = 0; cnt_clr = 0; stat_clr = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int c;
    bit e, cc, sc;
    reset = 1'b0; en = 0; cnt_in = 0; cnt_clr = 0; stat_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    s(5); check("lk5", int'(locked), 0);
    s(6); check("lk6", int'(locked), 0);
    s(7); check("lk7", int'(locked), 1);

    do_reset();
    lock_at(11); s(14); s(15); s(0);
    check("wrap_pulse", int'(wrap), 1);
    check("wrap_cnt1", int'(wrap_cnt), 1);
    s(1);
    check("wrap_drop", int'(wrap), 0);

    do_reset();
    lock_at(2); s(6);
    check("skip_err", int'(err), 1);
    check("skip_ecnt", int'(err_cnt), 1);
    check("skip_unlk", int'(locked), 0);
    s(7);
    check("err_1cyc", int'(err), 0);
    s(8);
    check("relock", int'(locked), 1);

    do_reset();
    lock_at(9);
    repeat (5) step(1'b0, 0, 1'b0, 1'b0);
    s(12);
    check("hold_lk", int'(locked), 1);
    check("hold_err", int'(err), 0);

    do_reset();
    lock_at(3);
    step(1'b1, 0, 1'b1, 1'b0);
    check("clr_noerr", int'(err), 0);
    check("clr_nowrap", int'(wrap), 0);
    s(1);
    check("clr_lk", int'(locked), 1);
    s(0);
    check("rep_err", int'(err), 1);

    do_reset();
    s(4); s(4);
    check("sync_noerr", int'(err), 0);

    for (int i = 0; i < 600; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      cc = ($urandom_range(0, 19) == 0);
      sc = ($urandom_range(0, 49) == 0);
      if (cc) c = 0;
      else if ($urandom_range(0, 9) < 8) c = (m_prev + 1) % 16;
      else c = $urandom_range(0, 15);
      step(e, c, cc, sc);
    end

    do_reset();
    while (m_errc < 255) begin
      c = $urandom_range(0, 15);
      lock_at(c);
      s(c + 7);
    end
    check("ecnt_255", int'(err_cnt), 255);
    lock_at(1); s(9);
    check("ecnt_sat", int'(err_cnt), 255);
    lock_at(4);
    step(1'b1, 12, 1'b0, 1'b1);
    check("sclr_err", int'(err), 1);
    check("sclr_cnt", int'(err_cnt), 0);

    lock_at(5); s(8);
    do_reset();
    check("rst_lk", int'(locked), 0);
    check("rst_ecnt", int'(err_cnt), 0);
    s(10); s(11);
    check("rst_relk", int'(locked), 0);
    s(12);
    check("rst_relk2", int'(locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Consumer-side monitor for the 4-bit free-running up-counter (count16 family).
- Samples the counter output every enabled clock, locks onto the sequence and flags any skipped, repeated or corrupted value.
- Reports legal wrap-arounds (max->0) and keeps saturating error and wrap counts.
- Sits beside the counter in the datapath or in self-checking benches as the reader for the counter's writer.

Parameters:
- WIDTH, 4, width of observed counter value; counter wraps at 2**WIDTH-1.
- LOCK_CNT, 3, consecutive in-sequence samples (including the first) needed to assert locked; legal range 2..15.
- CNT_W, 8, width of the saturating err_cnt and wrap_cnt.

Ports:
- clk  in  1  rising-edge clock, same domain as the counter.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- en  in  1  sample-valid; cnt_in is sampled on a rising edge only when en=1.
- cnt_in  in  WIDTH  observed counter value.
- cnt_clr  in  1  counter's own reset was applied; while 1, a sampled value of 0 is legal in any state.
- stat_clr  in  1  synchronous clear of err_cnt and wrap_cnt.
- locked  out  1  1 while the tracked sequence is verified.
- err  out  1  one-cycle pulse on a mismatch while locked.
- wrap  out  1  one-cycle pulse on a legal 2**WIDTH-1 -> 0 transition while locked.
- err_cnt  out  CNT_W  saturating mismatch count.
- wrap_cnt  out  CNT_W  saturating wrap count.

Behaviour:
- Reset (reset=0, async) sets: state=UNSYNC, exp=0, run=0, locked=0, err=0, wrap=0, err_cnt=0, wrap_cnt=0.
- All outputs are registered. Response to a sample taken at edge N is visible after edge N (latency 1).
- exp = next expected value = last sample + 1, computed mod 2**WIDTH.
- run = count of consecutive matching samples, saturating at LOCK_CNT.
- Edges with en=0 hold all state; err and wrap return to 0.
- State UNSYNC, en=1: exp<=cnt_in+1, run<=1, go to SYNCING.
- State SYNCING, en=1, match (cnt_in==exp, or cnt_clr=1 and cnt_in==0):
  - run<=run+1, exp<=cnt_in+1.
  - When run+1==LOCK_CNT: go to LOCKED, locked<=1.
- State SYNCING, en=1, mismatch: run<=1, exp<=cnt_in+1, stay in SYNCING. No err and no err_cnt increment.
- State LOCKED, en=1, match: exp<=cnt_in+1.
  - If the previous sample was 2**WIDTH-1 and cnt_in==0: wrap<=1, wrap_cnt increments.
  - A zero accepted via cnt_clr (previous value not max) is not a wrap.
- State LOCKED, en=1, mismatch:
  - err<=1, err_cnt increments, locked<=0.
  - Go to SYNCING with run<=1, exp<=cnt_in+1. The mismatching sample seeds resync.
- Counters saturate at 2**CNT_W-1 and never wrap.
- stat_clr=1 zeroes err_cnt and wrap_cnt. Clear wins over a same-cycle increment, but the err/wrap pulse still fires.
- cnt_clr with cnt_in!=0 gives no special treatment; normal match rules apply.
- Reset asserted mid-sequence returns to UNSYNC at once. After release, relock needs LOCK_CNT fresh samples.
- Repeated value (cnt_in==previous) is a mismatch, e.g. a counter held by its own reset while cnt_clr=0.

Decomposition:
- Package count_pkg:
  - state enum {UNSYNC, SYNCING, LOCKED}.
  - Default WIDTH=4.
  - Function next_val(v) returning v+1 mod 2**WIDTH.
- One sub-module, sat_counter (parameter W; inputs inc, clr; clr has priority). Instantiated twice, for err_cnt and wrap_cnt.

Test Plan:
- Reset low, drive en=1 with cnt_in 5,6,7 -> locked=0 after 5 and 6, locked=1 after 7; err=0 throughout.
- Lock, then feed 14,15,0,1 -> one wrap pulse after the 0 sample, wrap_cnt=1, err stays 0.
- Lock on 2,3,4, then feed 6 -> err=1 for exactly one cycle, err_cnt=1, locked=0. Then 7,8 -> locked=1 again.
- Lock on 9,10,11, hold en=0 for 5 cycles, then feed 12 with en=1 -> no err, locked stays 1.
- Lock on 3,4,5, feed 0 with cnt_clr=1 -> no err and no wrap. Feed 1 -> still locked. Feed 0 with cnt_clr=0 -> err pulse.
- Drive err_cnt to 255 with mismatches, inject one more -> stays 255. Pulse stat_clr on the same cycle as a mismatch -> err_cnt=0, err=1. Pull reset low mid-run -> all outputs 0 immediately.
